// File: rtl/ysyx_25020037_gpr_sb.sv
// ysyx_25020037_gpr_sb: register file with per-register pending-write
// counters (RAW scoreboard) and same-cycle write-through bypass.
// Ports:
//   clk, rst          clock, async active-high reset
//   alloc_valid/rd    issue requests a pending write; alloc_ready accepts
//   wb_valid/rd/we    write-back retires one pending write, optional data
//   wb_data           write-back data
//   flush             clears every pending counter
//   rd_addr/rd_data   NRD packed read ports (combinational, bypassed)
//   rd_busy           per-port outstanding-write flag
//   pend_err          sticky: release seen with a zero counter
module ysyx_25020037_gpr_sb #(
   parameter int XLEN   = 32,
   parameter int NREG   = 16,
   parameter int AW     = $clog2(NREG),
   parameter int NRD    = 2,
   parameter int PEND_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_valid,
   input  logic [AW-1:0]     alloc_rd,
   output logic              alloc_ready,
   input  logic              wb_valid,
   input  logic [AW-1:0]     wb_rd,
   input  logic              wb_we,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]    rd_busy,
   output logic              pend_err
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   logic [XLEN-1:0]   regs    [NREG];
   logic [PEND_W-1:0] cnt     [NREG];
   logic [PEND_W-1:0] cnt_nxt [NREG];

   logic wb_nz;
   logic wb_wr;
   logic rel;
   logic orphan;
   logic alloc_fire;

   assign wb_nz  = wb_valid && (wb_rd != '0);
   assign wb_wr  = wb_nz && wb_we;
   assign rel    = wb_nz && (cnt[wb_rd] != '0);
   assign orphan = wb_nz && (cnt[wb_rd] == '0);

   // A same-cycle release frees one slot, so a full counter
   // can still take an allocation when its own release lands.
   assign alloc_ready = !((alloc_rd != '0) &&
                          (cnt[alloc_rd] == CNT_MAX) &&
                          !(rel && (wb_rd == alloc_rd)));

   assign alloc_fire = alloc_valid && alloc_ready &&
                       (alloc_rd != '0);

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_nxt[r] = cnt[r];
         if (flush || (r == 0)) begin
            cnt_nxt[r] = '0;
         end else if (alloc_fire && (alloc_rd == AW'(r)) &&
                      !(rel && (wb_rd == AW'(r)))) begin
            cnt_nxt[r] = cnt[r] + PEND_W'(1);
         end else if (rel && (wb_rd == AW'(r)) &&
                      !(alloc_fire && (alloc_rd == AW'(r)))) begin
            cnt_nxt[r] = cnt[r] - PEND_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            regs[r] <= '0;
            cnt[r]  <= '0;
         end
         pend_err <= 1'b0;
      end else begin
         if (wb_wr) begin
            regs[wb_rd] <= wb_data;
         end
         for (int r = 0; r < NREG; r++) begin
            cnt[r] <= cnt_nxt[r];
         end
         if (orphan) begin
            pend_err <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] a;
      logic          hit;
      logic          own;

      assign a   = rd_addr[i*AW +: AW];
      assign hit = wb_wr && (wb_rd == a);
      // A final release this cycle already reads as not busy.
      assign own = rel && (wb_rd == a);

      assign rd_data[i*XLEN +: XLEN] =
         (a == '0) ? '0 :
         hit       ? wb_data :
                     regs[a];

      assign rd_busy[i] = (a != '0) &&
                          ((cnt[a] - PEND_W'(own)) != '0);
   end

endmodule

// File: tb/tb_ysyx_25020037_gpr_sb.sv
// tb_ysyx_25020037_gpr_sb: directed plus randomized bench for the
// register file / scoreboard, NREG=32, NRD=3, PEND_W=2.
module tb_ysyx_25020037_gpr_sb;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int AW     = 5;
   localparam int NRD    = 3;
   localparam int PEND_W = 2;
   localparam int MAXC   = 3;

   logic              clk;
   logic              rst;
   logic              alloc_valid;
   logic [AW-1:0]     alloc_rd;
   logic              alloc_ready;
   logic              wb_valid;
   logic [AW-1:0]     wb_rd;
   logic              wb_we;
   logic [XLEN-1:0]   wb_data;
   logic              flush;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic              pend_err;

   int checks;
   int failures;

   logic [31:0] m_reg [NREG];
   int          m_cnt [NREG];
   bit          m_err;

   ysyx_25020037_gpr_sb #(
      .XLEN(XLEN), .NREG(NREG), .AW(AW),
      .NRD(NRD), .PEND_W(PEND_W)
   ) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
      .alloc_ready(alloc_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
      .wb_data(wb_data), .flush(flush),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .pend_err(pend_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NREG; r++) begin
         m_reg[r] = '0;
         m_cnt[r] = 0;
      end
      m_err = 1'b0;
   endtask

   function automatic bit m_rel();
      return wb_valid && (wb_rd != 0) && (m_cnt[wb_rd] > 0);
   endfunction

   function automatic bit m_ready();
      if (alloc_rd == 0) return 1'b1;
      if (m_cnt[alloc_rd] < MAXC) return 1'b1;
      return m_rel() && (wb_rd == alloc_rd);
   endfunction

   task automatic check_all(string tag);
      logic [AW-1:0] a;
      logic [31:0]   ed;
      int            pend;
      for (int i = 0; i < NRD; i++) begin
         a = rd_addr[i*AW +: AW];
         if (a == 0) ed = '0;
         else if (wb_valid && wb_we && wb_rd == a) ed = wb_data;
         else ed = m_reg[a];
         pend = (a == 0) ? 0 : m_cnt[a];
         if (a != 0 && m_rel() && wb_rd == a) pend = pend - 1;
         chk($sformatf("%s.data%0d", tag, i),
             rd_data[i*XLEN +: XLEN], ed);
         chk($sformatf("%s.busy%0d", tag, i),
             32'(rd_busy[i]), 32'(pend > 0));
      end
      chk({tag, ".ready"}, 32'(alloc_ready), 32'(m_ready()));
      chk({tag, ".err"}, 32'(pend_err), 32'(m_err));
   endtask

   task automatic model_update();
      bit rel;
      bit acc;
      rel = m_rel();
      acc = alloc_valid && (alloc_rd != 0) && m_ready();
      if (wb_valid && wb_rd != 0 && m_cnt[wb_rd] == 0) m_err = 1'b1;
      if (wb_valid && wb_we && wb_rd != 0) m_reg[wb_rd] = wb_data;
      if (flush) begin
         for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      end else begin
         if (acc) m_cnt[alloc_rd] = m_cnt[alloc_rd] + 1;
         if (rel) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
      end
   endtask

   task automatic idle();
      alloc_valid = 1'b0;
      alloc_rd    = '0;
      wb_valid    = 1'b0;
      wb_rd       = '0;
      wb_we       = 1'b0;
      wb_data     = '0;
      flush       = 1'b0;
   endtask

   task automatic set_rd(logic [AW-1:0] a0, logic [AW-1:0] a1,
                         logic [AW-1:0] a2);
      rd_addr = {a2, a1, a0};
   endtask

   task automatic alloc(logic [AW-1:0] r);
      alloc_valid = 1'b1;
      alloc_rd    = r;
   endtask

   task automatic wb(logic [AW-1:0] r, logic we, logic [31:0] d);
      wb_valid = 1'b1;
      wb_rd    = r;
      wb_we    = we;
      wb_data  = d;
   endtask

   // Inputs change at posedge+1; outputs are sampled mid-cycle.
   task automatic settle(string tag);
      #3;
      check_all(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic cyc(string tag);
      settle(tag);
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      model_reset();
      idle();
      set_rd(0, 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      set_rd(0, 1, 31);
      settle("reset");
      chk("reset.ready", 32'(alloc_ready), 32'd1);
      chk("reset.busy", 32'(rd_busy), 32'd0);
      tick();

      wb(0, 1'b1, 32'hDEADBEEF);
      set_rd(0, 0, 0);
      settle("x0_wr");
      chk("x0_wr.byp", rd_data[31:0], 32'd0);
      tick();
      idle();
      settle("x0_rd");
      chk("x0_rd.data", rd_data[31:0], 32'd0);
      tick();

      alloc(5);
      set_rd(5, 0, 0);
      settle("a5");
      chk("a5.busy_now", 32'(rd_busy[0]), 32'd0);
      tick();
      idle();
      settle("a5_next");
      chk("a5.busy_next", 32'(rd_busy[0]), 32'd1);
      tick();
      wb(5, 1'b1, 32'h12345678);
      settle("wb5");
      chk("wb5.busy", 32'(rd_busy[0]), 32'd0);
      chk("wb5.byp", rd_data[31:0], 32'h12345678);
      tick();
      idle();
      settle("wb5_arr");
      chk("wb5.arr", rd_data[31:0], 32'h12345678);
      tick();

      for (int k = 0; k < 3; k++) begin
         idle();
         alloc(3);
         cyc("a3");
      end
      idle();
      alloc(3);
      set_rd(3, 7, 0);
      settle("a3_full");
      chk("a3_full.ready", 32'(alloc_ready), 32'd0);
      tick();
      alloc(7);
      settle("a7");
      chk("a7.ready", 32'(alloc_ready), 32'd1);
      tick();
      alloc(3);
      wb(3, 1'b0, 32'h0);
      settle("a3_rel");
      chk("a3_rel.ready", 32'(alloc_ready), 32'd1);
      tick();
      idle();
      alloc_rd = 3;
      settle("a3_still");
      chk("a3_still.ready", 32'(alloc_ready), 32'd0);
      chk("a3_still.busy", 32'(rd_busy[0]), 32'd1);
      tick();

      idle();
      alloc(9);
      cyc("a9");
      alloc(10);
      cyc("a10");
      idle();
      flush = 1'b1;
      wb(9, 1'b1, 32'hA5A5A5A5);
      cyc("flush");
      idle();
      set_rd(9, 10, 3);
      settle("post_flush");
      chk("post_flush.x9", rd_data[31:0], 32'hA5A5A5A5);
      chk("post_flush.busy", 32'(rd_busy), 32'd0);
      chk("post_flush.err", 32'(pend_err), 32'd0);
      tick();

      wb(4, 1'b1, 32'h1);
      set_rd(4, 0, 0);
      cyc("orphan");
      idle();
      settle("orphan_after");
      chk("orphan.err", 32'(pend_err), 32'd1);
      chk("orphan.x4", rd_data[31:0], 32'h1);
      tick();
      alloc(6);
      cyc("traffic_a");
      idle();
      wb(6, 1'b1, 32'h66);
      cyc("traffic_w");
      idle();
      settle("err_hold");
      chk("err_hold.err", 32'(pend_err), 32'd1);
      tick();

      alloc(8);
      set_rd(4, 8, 5);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all("rst_mid");
      chk("rst_mid.err", 32'(pend_err), 32'd0);
      chk("rst_mid.x4", rd_data[31:0], 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      settle("rst_after");
      chk("rst_after.busy8", 32'(rd_busy[1]), 32'd0);
      tick();

      wb(31, 1'b1, 32'hCAFEF00D);
      cyc("w31");
      wb(16, 1'b1, 32'h0BADC0DE);
      set_rd(31, 0, 16);
      settle("3port");
      chk("3port.x31", rd_data[31:0], 32'hCAFEF00D);
      chk("3port.x0", rd_data[63:32], 32'd0);
      chk("3port.x16", rd_data[95:64], 32'h0BADC0DE);
      tick();

      for (int n = 0; n < 400; n++) begin
         alloc_valid = ($urandom_range(0, 3) != 0);
         alloc_rd    = AW'($urandom_range(0, 7));
         wb_valid    = ($urandom_range(0, 1) != 0);
         wb_rd       = AW'($urandom_range(0, 7));
         wb_we       = ($urandom_range(0, 1) != 0);
         wb_data     = $urandom;
         flush       = ($urandom_range(0, 31) == 0);
         set_rd(($urandom_range(0, 3) == 0) ? wb_rd :
                   AW'($urandom_range(0, 7)),
                AW'($urandom_range(0, 7)),
                ($urandom_range(0, 1) == 0) ? alloc_rd :
                   AW'($urandom_range(0, 31)));
         cyc("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
